// File: rtl/icache_nway.sv
// N-way set-associative instruction cache between fetch and the AXI read bridge.
// Per-set round-robin replacement preferring invalid ways; uncached fetch, invalidate sweep, flush.
module icache_nway #(
    parameter int WAYS       = 4,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    input  logic                     req_uncached,
    output logic                     req_ready,
    input  logic                     flush,
    input  logic                     inv_all,
    output logic                     resp_valid,
    output logic [31:0]              resp_inst,
    output logic [31:0]              resp_addr,
    output logic                     rd_req,
    output logic [31:0]              rd_addr,
    input  logic                     ret_valid,
    input  logic [32*LINE_WORDS-1:0] ret_data
);
    localparam int OFFSET_W = $clog2(LINE_WORDS * 4);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    localparam int WORD_W   = $clog2(LINE_WORDS);
    localparam int PTR_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {INV, IDLE, LOOKUP, MISS} state_t;

    state_t               state, state_nx;
    logic [INDEX_W-1:0]   inv_idx;
    logic                 inv_pend;
    logic                 kill;

    logic [SETS-1:0]      line_vld [WAYS];
    logic [TAG_W-1:0]     tag_ram  [WAYS][SETS];
    logic [31:0]          data_ram [WAYS][SETS][LINE_WORDS];
    logic [PTR_W-1:0]     rr_ptr   [SETS];

    logic [31:0]          addr_p1;
    logic                 unc_p1;
    logic [TAG_W-1:0]     tag_p1  [WAYS];
    logic [31:0]          word_p1 [WAYS];
    logic [WAYS-1:0]      line_vld_p1;

    logic                 accept;
    logic                 lookup_hit;
    logic [31:0]          hit_word;
    logic [31:0]          ret_word;
    logic                 go_miss;
    logic                 install;
    logic                 inv_start;
    logic                 any_inv;
    logic [PTR_W-1:0]     victim;
    logic [PTR_W-1:0]     rr_next;
    logic [INDEX_W-1:0]   miss_idx;

    function automatic logic [INDEX_W-1:0] index_of(input logic [31:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input logic [31:0] a);
        return a[2 +: WORD_W];
    endfunction

    assign accept   = req_valid && req_ready;
    assign miss_idx = index_of(addr_p1);

    // Stage p1: tag compare across all ways on the registered read
    always_comb begin
        lookup_hit = 1'b0;
        hit_word   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (line_vld_p1[w] && (tag_p1[w] == tag_of(addr_p1))) begin
                lookup_hit = 1'b1;
                hit_word   = hit_word | word_p1[w];
            end
        end
        if (unc_p1) lookup_hit = 1'b0;
    end

    always_comb begin
        ret_word = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (word_of(addr_p1) == WORD_W'(i)) ret_word = ret_data[32*i +: 32];
        end
    end

    // Lowest invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        victim  = rr_ptr[miss_idx];
        any_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!any_inv && !line_vld[w][miss_idx]) begin
                victim  = PTR_W'(w);
                any_inv = 1'b1;
            end
        end
        rr_next = (rr_ptr[miss_idx] == PTR_W'(WAYS - 1)) ? '0 : rr_ptr[miss_idx] + 1'b1;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_inst  = '0;
        resp_addr  = '0;
        rd_req     = 1'b0;
        go_miss    = 1'b0;
        install    = 1'b0;
        inv_start  = 1'b0;
        case (state)
            INV: begin
                if (inv_idx == INDEX_W'(SETS - 1)) state_nx = IDLE;
            end
            IDLE: begin
                if (inv_all || inv_pend) begin
                    state_nx  = INV;
                    inv_start = 1'b1;
                end else if (!flush) begin
                    req_ready = 1'b1;
                    if (req_valid) state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                resp_addr = addr_p1;
                resp_inst = hit_word;
                if (flush) begin
                    state_nx = IDLE;
                end else if (lookup_hit) begin
                    resp_valid = 1'b1;
                    req_ready  = !(inv_all || inv_pend);
                    state_nx   = (req_valid && req_ready) ? LOOKUP : IDLE;
                end else begin
                    state_nx = MISS;
                    go_miss  = 1'b1;
                end
            end
            MISS: begin
                resp_addr = addr_p1;
                resp_inst = unc_p1 ? ret_data[31:0] : ret_word;
                if (ret_valid) begin
                    resp_valid = !kill && !flush;
                    install    = !unc_p1;
                    state_nx   = IDLE;
                end else begin
                    rd_req = 1'b1;
                end
            end
            default: state_nx = INV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INV;
            inv_idx  <= '0;
            inv_pend <= 1'b0;
            kill     <= 1'b0;
            rd_addr  <= '0;
        end else begin
            state <= state_nx;
            if (inv_start) inv_idx <= '0;
            else if (state == INV) inv_idx <= inv_idx + 1'b1;
            if (inv_start) inv_pend <= 1'b0;
            else if (inv_all && state != IDLE) inv_pend <= 1'b1;
            // kill survives until the refill completes so the late response is dropped
            if (state != MISS || ret_valid) kill <= 1'b0;
            else if (flush) kill <= 1'b1;
            if (go_miss) rd_addr <= unc_p1 ? addr_p1 : {addr_p1[31:OFFSET_W], {OFFSET_W{1'b0}}};
        end
    end

    // Stage p0 -> p1: array read on accept, refill write and sweep clear
    always_ff @(posedge clk) begin
        if (state == INV) begin
            for (int w = 0; w < WAYS; w++) line_vld[w][inv_idx] <= 1'b0;
            rr_ptr[inv_idx] <= '0;
        end else if (install && !reset) begin
            line_vld[victim][miss_idx] <= 1'b1;
            tag_ram[victim][miss_idx]  <= tag_of(addr_p1);
            for (int i = 0; i < LINE_WORDS; i++) data_ram[victim][miss_idx][i] <= ret_data[32*i +: 32];
            if (!any_inv) rr_ptr[miss_idx] <= rr_next;
        end
        if (accept) begin
            addr_p1 <= req_addr;
            unc_p1  <= req_uncached;
            for (int w = 0; w < WAYS; w++) begin
                tag_p1[w]      <= tag_ram[w][index_of(req_addr)];
                word_p1[w]     <= data_ram[w][index_of(req_addr)][word_of(req_addr)];
                line_vld_p1[w] <= line_vld[w][index_of(req_addr)];
            end
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway: fills, hits, streaming, eviction order, flush, uncached, invalidate.
module tb_icache_nway;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic [31:0]     req_addr;
    logic            req_uncached;
    logic            req_ready;
    logic            flush;
    logic            inv_all;
    logic            resp_valid;
    logic [31:0]     resp_inst;
    logic [31:0]     resp_addr;
    logic            rd_req;
    logic [31:0]     rd_addr;
    logic            ret_valid;
    logic [32*LW-1:0] ret_data;

    always #5 clk = ~clk;

    icache_nway dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_uncached(req_uncached), .req_ready(req_ready), .flush(flush), .inv_all(inv_all),
        .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_addr(resp_addr),
        .rd_req(rd_req), .rd_addr(rd_addr), .ret_valid(ret_valid), .ret_data(ret_data)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:16] == 16'h1C00) return 32'hA000_0000 | {29'd0, a[4:2]};
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] unc_word(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic logic [32*LW-1:0] line_data(input logic [31:0] base, input bit unc);
        logic [32*LW-1:0] d;
        for (int i = 0; i < LW; i++)
            d[32*i +: 32] = unc ? (32'hDEAD_0000 | 32'(i)) : mem_word(base + 32'(4 * i));
        if (unc) d[31:0] = unc_word(base);
        return d;
    endfunction

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'(exp_q.size()), 64'(1));
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_inst", 64'(resp_inst), 64'(mon_e.inst));
                check("resp_addr", 64'(resp_addr), 64'(mon_e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!req_ready && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    task automatic send(input logic [31:0] a, input bit unc, input bit push);
        int k = 0;
        req_valid = 1'b1;
        req_addr = a;
        req_uncached = unc;
        #1;
        while (!req_ready && k < 400) begin
            tick();
            k++;
        end
        check("req_accept", 64'(req_ready), 64'(1));
        if (push) exp_q.push_back('{inst: (unc ? unc_word(a) : mem_word(a)), addr: a});
        tick();
        req_valid = 1'b0;
        req_uncached = 1'b0;
        #1;
    endtask

    task automatic hit(input logic [31:0] a);
        send(a, 1'b0, 1'b1);
        check("hit_resp_vld", 64'(resp_valid), 64'(1));
        check("hit_no_rd", 64'(rd_req), 64'(0));
    endtask

    task automatic serve(input logic [31:0] ra, input bit unc, input int dly, input bit fl);
        check("rd_addr", 64'(rd_addr), 64'(ra));
        repeat (dly) begin
            tick();
            check("rd_req_held", 64'(rd_req), 64'(1));
            check("rd_addr_stable", 64'(rd_addr), 64'(ra));
        end
        ret_data = line_data(ra, unc);
        ret_valid = 1'b1;
        flush = fl;
        #1;
        check("rd_req_drop", 64'(rd_req), 64'(0));
        check("ret_resp_vld", 64'(resp_valid), 64'(!fl));
        tick();
        ret_valid = 1'b0;
        flush = 1'b0;
        ret_data = '0;
        #1;
        check("ready_after_ret", 64'(req_ready), 64'(1));
    endtask

    task automatic miss(input logic [31:0] a, input bit unc, input int dly);
        logic [31:0] ra;
        ra = unc ? a : {a[31:5], 5'd0};
        send(a, unc, 1'b1);
        check("miss_no_resp", 64'(resp_valid), 64'(0));
        tick();
        check("miss_rd_lat", 64'(rd_req), 64'(1));
        serve(ra, unc, dly, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_uncached = 1'b0;
        flush = 1'b0; inv_all = 1'b0; ret_valid = 1'b0; ret_data = '0;
        repeat (2) tick();
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_inst", 64'(resp_inst), 64'(0));
        check("rst_resp_addr", 64'(resp_addr), 64'(0));
        check("rst_rd_req", 64'(rd_req), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        tick();
        reset = 1'b0;
        wait_ready(n);
        check("rst_ready_lat", 64'(n), 64'(128));

        miss(32'h1C00_0000, 1'b0, 3);
        hit(32'h1C00_0004);

        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_addr = 32'h1C00_0000 + 32'(4 * k);
            #1;
            check("stream_rdy", 64'(req_ready), 64'(1));
            exp_q.push_back('{inst: mem_word(req_addr), addr: req_addr});
            tick();
            check("stream_vld", 64'(resp_valid), 64'(1));
        end
        req_valid = 1'b0;
        tick();

        inv_all = 1'b1;
        #1;
        check("inv_pulse_rdy", 64'(req_ready), 64'(0));
        tick();
        inv_all = 1'b0;
        wait_ready(n);
        check("inv_ready_lat", 64'(n), 64'(128));
        miss(32'h1C00_0000, 1'b0, 1);

        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        wait_ready(n);
        check("inv2_ready_lat", 64'(n), 64'(128));

        miss(32'h0000_0000, 1'b0, 0);
        miss(32'h0000_1000, 1'b0, 0);
        miss(32'h0000_2000, 1'b0, 0);
        miss(32'h0000_3000, 1'b0, 0);
        miss(32'h0000_4000, 1'b0, 0);
        miss(32'h0000_0000, 1'b0, 1);
        hit(32'h0000_2000);
        miss(32'h0000_1000, 1'b0, 0);
        hit(32'h0000_3000);
        hit(32'h0000_4000);

        send(32'h0000_8000, 1'b0, 1'b0);
        tick();
        check("fl_miss_rd", 64'(rd_req), 64'(1));
        repeat (3) tick();
        flush = 1'b1;
        #1;
        check("fl_miss_rd_hold", 64'(rd_req), 64'(1));
        check("fl_miss_no_resp", 64'(resp_valid), 64'(0));
        tick();
        flush = 1'b0;
        repeat (4) tick();
        ret_data = line_data(32'h0000_8000, 1'b0);
        ret_valid = 1'b1;
        #1;
        check("fl_kill_resp", 64'(resp_valid), 64'(0));
        tick();
        ret_valid = 1'b0;
        #1;
        check("fl_ready_after", 64'(req_ready), 64'(1));
        hit(32'h0000_8000);

        send(32'h0000_8004, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_lk_vld", 64'(resp_valid), 64'(0));
        check("fl_lk_rdy", 64'(req_ready), 64'(0));
        tick();
        flush = 1'b0;
        #1;
        check("fl_lk_idle_rdy", 64'(req_ready), 64'(1));
        hit(32'h0000_8004);

        send(32'h0000_0040, 1'b0, 1'b0);
        tick();
        check("fl_ret_rd", 64'(rd_req), 64'(1));
        serve(32'h0000_0040, 1'b0, 2, 1'b1);
        hit(32'h0000_0040);

        miss(32'h1FE0_0010, 1'b1, 2);
        miss(32'h1FE0_0010, 1'b1, 1);
        miss(32'h1FE0_0010, 1'b0, 1);
        hit(32'h1FE0_0014);

        send(32'h0000_00A0, 1'b0, 1'b0);
        tick();
        check("rmid_rd", 64'(rd_req), 64'(1));
        reset = 1'b1;
        tick();
        check("rmid_rd_drop", 64'(rd_req), 64'(0));
        reset = 1'b0;
        wait_ready(n);
        check("rmid_ready_lat", 64'(n), 64'(128));
        miss(32'h0000_8000, 1'b0, 0);

        tick();
        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
